// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and framing constants.
package im_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        ADDR,
        DATA,
        CSUM
    } loaderState_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT  = 8'hA5;
    localparam bit         LEN_ZERO_MEANS_256 = 1'b1;

endpackage

// File: rtl/im_loader.sv
// Frame-driven instruction-memory loader: writes payload bytes to sequential addresses
// and holds the processor in reset until a frame with a good checksum has landed.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         DATA_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    loaderState_t      state;
    logic [7:0]        sum;
    logic [8:0]        count;
    logic [ADDR_W-1:0] wptr;
    logic              accept;
    logic [7:0]        sumNext;

    // The loader never applies backpressure.
    assign in_ready = 1'b1;
    assign accept   = in_valid && in_ready;
    assign sumNext  = sum + in_data;

    // Frame parser; the write strobe is a one-cycle pulse following each accepted payload byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            wptr      <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state <= LEN;
                            if (!cpu_hold) begin
                                cpu_hold  <= 1'b1;
                                load_done <= 1'b0;
                                load_err  <= 1'b0;
                            end
                        end
                    end
                    LEN: begin
                        if (LEN_ZERO_MEANS_256 && in_data == 8'h00)
                            count <= 9'd256;
                        else
                            count <= {1'b0, in_data};
                        sum   <= in_data;
                        state <= ADDR;
                    end
                    ADDR: begin
                        wptr  <= ADDR_W'(in_data);
                        sum   <= sumNext;
                        state <= DATA;
                    end
                    DATA: begin
                        im_we    <= 1'b1;
                        im_addr  <= wptr;
                        im_wdata <= DATA_W'(in_data);
                        wptr     <= wptr + 1'b1;
                        sum      <= sumNext;
                        count    <= count - 9'd1;
                        if (count == 9'd1)
                            state <= CSUM;
                    end
                    CSUM: begin
                        if (sumNext == 8'h00) begin
                            load_done <= 1'b1;
                            load_err  <= 1'b0;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_done <= 1'b0;
                            load_err  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: stimulus queues expected writes, a monitor pops them on im_we.
module tb_im_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       im_we;
    logic [7:0] im_addr;
    logic [7:0] im_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] expWrites[$];
    logic [7:0]  txPayload[$];

    im_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .im_we(im_we),
        .im_addr(im_addr),
        .im_wdata(im_wdata),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (im_we) begin
            vectors++;
            if (expWrites.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpectedWrite: addr=%02h data=%02h, none expected", im_addr, im_wdata);
            end else begin
                logic [15:0] exp;
                exp = expWrites.pop_front();
                if ({im_addr, im_wdata} !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL write: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                             im_addr, im_wdata, exp[15:8], exp[7:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic sendGapped(input logic [7:0] b, input bit gaps);
        sendByte(b);
        if (gaps) idleCycles($urandom_range(1, 3));
    endtask

    // Sends a whole frame from txPayload and queues the writes it should produce.
    task automatic applyStimulus(input logic [7:0] len, input logic [7:0] addr,
                                 input logic [7:0] csum, input bit gaps);
        logic [7:0] a;
        a = addr;
        sendGapped(8'hA5, gaps);
        sendGapped(len, gaps);
        sendGapped(addr, gaps);
        foreach (txPayload[i]) begin
            expWrites.push_back({a, txPayload[i]});
            a = a + 8'd1;
            sendGapped(txPayload[i], gaps);
        end
        sendByte(csum);
        idleCycles(2);
    endtask

    task automatic checkStatus(input string tag, input logic done, input logic err, input logic hold);
        checkOutput({tag, ".load_done"}, 32'(load_done), 32'(done));
        checkOutput({tag, ".load_err"}, 32'(load_err), 32'(err));
        checkOutput({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
        checkOutput({tag, ".pendingWrites"}, 32'(expWrites.size()), 32'd0);
    endtask

    task automatic loadBasic();
        txPayload = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h03, 8'h10, 8'h87, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset.im_we", 32'(im_we), 32'd0);
        checkOutput("reset.im_addr", 32'(im_addr), 32'd0);
        checkOutput("reset.im_wdata", 32'(im_wdata), 32'd0);
        checkStatus("reset", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        idleCycles(2);

        loadBasic();
        checkStatus("basic", 1'b1, 1'b0, 1'b0);

        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h5A);
        idleCycles(2);
        checkStatus("garbage", 1'b1, 1'b0, 1'b0);
        loadBasic();
        checkStatus("garbageBasic", 1'b1, 1'b0, 1'b0);

        txPayload = '{8'hAA, 8'hBB};
        applyStimulus(8'h02, 8'hFF, 8'h9A, 1'b1);
        checkStatus("wrap", 1'b1, 1'b0, 1'b0);

        txPayload = '{8'h55};
        applyStimulus(8'h01, 8'h20, 8'h00, 1'b0);
        checkStatus("badCsum", 1'b0, 1'b1, 1'b1);

        txPayload.delete();
        for (int i = 0; i < 256; i++) txPayload.push_back(8'(i));
        applyStimulus(8'h00, 8'h00, 8'h80, 1'b0);
        checkStatus("full", 1'b1, 1'b0, 1'b0);

        sendByte(8'hA5);
        checkOutput("reload.cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("reload.load_done", 32'(load_done), 32'd0);
        sendByte(8'h03);
        sendByte(8'h40);
        expWrites.push_back({8'h40, 8'h11});
        sendByte(8'h11);
        sendByte(8'h22);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.im_we", 32'(im_we), 32'd0);
        checkOutput("abort.im_addr", 32'(im_addr), 32'd0);
        in_valid = 1'b0;
        idleCycles(2);
        checkStatus("abort", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        idleCycles(2);

        loadBasic();
        checkStatus("afterAbort", 1'b1, 1'b0, 1'b0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
